// File: rtl/fir_mac_engine.sv
// Time-multiplexed single-multiplier FIR: one full convolution per accepted Q1.15 sample.
// Emits the full-precision accumulator; rounding and saturation happen downstream.
module fir_mac_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 20,
  parameter int COEFF_FRAC  = 17,
  parameter int NUM_TAPS    = 32,
  parameter int ACC_WIDTH   = 42
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic signed [DATA_WIDTH-1:0]      data_in,
  input  logic                              valid_in,
  output logic                              ready,
  input  logic                              coeff_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0]       coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0]     coeff_data,
  output logic signed [ACC_WIDTH-1:0]       acc_out,
  output logic                              valid_out,
  output logic                              overrun,
  output logic                              coeff_wr_err
);
  // state | meaning
  // IDLE  | waiting for a sample, coefficient writes allowed
  // MAC   | one product per cycle, accumulating the previous one
  // FLUSH | add the last product, load acc_out
  // OUT   | result valid; may accept the next sample like IDLE

  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);

  if ((NUM_TAPS < 2) || (NUM_TAPS > 64) || ((NUM_TAPS & (NUM_TAPS - 1)) != 0) ||
      (ACC_WIDTH < PROD_W + TAP_W) || (DATA_WIDTH - 1 + COEFF_FRAC != 32)) begin : g_bad_params
    $error("fir_mac_engine: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;
  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0]  dline [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] coeff [NUM_TAPS];
  logic [TAP_W-1:0]              wr_ptr, base, tap, rd_idx;
  logic signed [PROD_W-1:0]      prod, prod_nxt, x_ext, h_ext;
  logic signed [ACC_WIDTH-1:0]   acc, prod_ext;
  logic                          accept, coeff_we;

  assign ready    = (state == IDLE) || (state == OUT);
  assign accept   = ready && valid_in;
  assign coeff_we = ready && coeff_wr_en;
  // Newest sample sits at base; older taps walk backwards around the circular line.
  assign rd_idx   = base - tap;
  assign x_ext    = {{COEFF_WIDTH{dline[rd_idx][DATA_WIDTH-1]}}, dline[rd_idx]};
  assign h_ext    = {{DATA_WIDTH{coeff[tap][COEFF_WIDTH-1]}}, coeff[tap]};
  assign prod_nxt = x_ext * h_ext;
  assign prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, OUT: state_nxt = valid_in ? MAC : IDLE;
      MAC:       if (tap == TAP_LAST) state_nxt = FLUSH;
      FLUSH:     state_nxt = OUT;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        dline[i] <= '0;
        coeff[i] <= '0;
      end
      wr_ptr <= '0;
    end else begin
      if (accept) begin
        dline[wr_ptr] <= data_in;
        wr_ptr        <= wr_ptr + TAP_W'(1);
      end
      if (coeff_we) coeff[coeff_addr] <= coeff_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base         <= '0;
      tap          <= '0;
      prod         <= '0;
      acc          <= '0;
      acc_out      <= '0;
      valid_out    <= 1'b0;
      overrun      <= 1'b0;
      coeff_wr_err <= 1'b0;
    end else begin
      valid_out    <= 1'b0;
      overrun      <= valid_in && !ready;
      coeff_wr_err <= coeff_wr_en && !ready;
      case (state)
        IDLE, OUT: begin
          if (accept) begin
            base <= wr_ptr;
            tap  <= '0;
            acc  <= '0;
          end
        end
        MAC: begin
          prod <= prod_nxt;
          tap  <= tap + TAP_W'(1);
          // The product register is still empty on the first MAC cycle.
          if (tap != '0) acc <= acc + prod_ext;
        end
        FLUSH: begin
          acc       <= acc + prod_ext;
          acc_out   <= acc + prod_ext;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
